sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's fixed 16-bit x 512 FIFO. Generalised data width and depth. All DEPTH entries are usable, tracked with an occupancy counter. Adds programmable almost-full/almost-empty thresholds, a read-valid strobe, and full-state write-through. Buffers byte/lane streams between the input packer and the SHA3-512 absorb stage.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 9, address width; DEPTH = 2**ADDR_W (default 512)
AFULL_TH, 2**ADDR_W-4, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH

Ports:
clk  in  1  rising-edge clock (one clock domain)
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data; rd_data returns it bit-for-bit, same ordering
rd_en  in  1  read request
rd_data  out  DATA_W  registered read data
rd_valid  out  1  one-cycle strobe: rd_data updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky write-when-full-rejected flag (optional feature)
underflow  out  1  sticky read-when-empty flag (optional feature)
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Storage array is not reset. Reset mid-stream discards all contents.
- rd_accept = rd_en & ~empty.
- wr_accept = wr_en & (~full | rd_accept). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- Write: on clk edge with wr_accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read: on clk edge with rd_accept, rd_data <= mem[rd_ptr], rd_ptr increments, rd_valid=1 next cycle. Latency is 1 cycle from rd_en to rd_valid.
- When no read is accepted, rd_data holds its previous value and rd_valid=0.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- count update: +1 on write only; -1 on read only; unchanged when both or neither are accepted.
- Simultaneous read and write with count == 0: the read is rejected (no bypass), the write is accepted, and count becomes 1.
- Simultaneous read and write with count == DEPTH: both are accepted, count stays DEPTH, and the read returns the oldest word.
- Status flags are combinational decodes of the count register only. No input-to-flag combinational path.
- Elaboration check: AEMPTY_TH < AFULL_TH <= DEPTH; otherwise a fatal elaboration error.

Optional Feature:
Macro SHA3_FIFO_ERRFLAG_EN.
- Defined:
  - overflow sets on wr_en & ~wr_accept.
  - underflow sets on rd_en & empty.
  - Both hold until err_clr=1 or reset. err_clr has priority over a same-cycle set.
- Undefined: overflow and underflow are tied 0 and err_clr is ignored. The port list is identical in both builds.

Decomposition:
- Shared package sha3_fifo_pkg holds:
  - default width/depth constants (FIFO_DATA_W=16, FIFO_ADDR_W=9);
  - the clog2-style depth helper function;
  - the threshold sanity-check function.
- Sub-module fifo_dp_ram: simple dual-port array, one write port and one synchronous read port with read enable, parametrised DATA_W/ADDR_W. Infers block RAM.
- Pointer, count, flag and handshake logic live in sync_fifo_param.

Test Plan:
1. Reset, then write 0x0001..0x0005 and read 5 -> rd_data 0x0001..0x0005 in order, each one cycle after rd_en with rd_valid pulsed; empty=1 at the end and count=0.
2. Write 512 words with no reads -> full=1 and count=512 after the 512th; the 513th wr_en is rejected; overflow=1 with the macro, 0 without it.
3. At count=512, assert wr_en=rd_en with wr_data=0xBEEF -> count stays 512, rd_data is the oldest word; after draining, 0xBEEF is the last word out.
4. Empty FIFO, wr_en=rd_en=1 with 0x1234 -> rd_valid=0, count=1; the next read returns 0x1234; underflow=1 with the macro. Then pulse err_clr -> flags return to 0.
5. Thresholds at defaults:
   - almost_empty=1 at count 4 and 0 at count 5;
   - almost_full=0 at count 507 and 1 at count 508.
6. Fill to 600 total writes across interleaved reads (pointer wrap), then pull rst_n low mid-burst -> all outputs reach reset values immediately (async); after release, empty=1 and the first new write reads back correctly.

Source files
------------

// File: rtl/sha3_fifo_pkg.sv
// ============================================================================
// Module      : sha3_fifo_pkg
// Description : Shared constants and elaboration helpers for the SHA3 FIFO.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package sha3_fifo_pkg;

   localparam int unsigned FIFO_DATA_W = 16;
   localparam int unsigned FIFO_ADDR_W = 9;

   // Inverse of clog2: number of entries addressed by an addr_w-bit pointer.
   function automatic int unsigned fifo_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   function automatic bit fifo_th_ok(input int unsigned aempty_th,
                                     input int unsigned afull_th,
                                     input int unsigned depth);
      return (aempty_th < afull_th) && (afull_th <= depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_dp_ram.sv
// ============================================================================
// Module      : fifo_dp_ram
// Description : Simple dual-port array, one write port, one registered read
//               port with read enable. Read output holds when not enabled.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fifo_dp_ram
   import sha3_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned c_depth = fifo_depth(ADDR_W);

   logic [DATA_W-1:0] mem_q [c_depth];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Storage is intentionally left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy counter,
//               thresholds and read-valid strobe. Sticky overflow/underflow
//               flags are built only when SHA3_FIFO_ERRFLAG_EN is defined.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sync_fifo_param
   import sha3_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned ADDR_W    = FIFO_ADDR_W,
   parameter int unsigned AFULL_TH  = fifo_depth(ADDR_W) - 4,
   parameter int unsigned AEMPTY_TH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam int unsigned     c_depth_i = fifo_depth(ADDR_W);
   localparam int unsigned     c_cnt_w   = ADDR_W + 1;
   localparam logic [ADDR_W:0] c_depth   = c_cnt_w'(c_depth_i);
   localparam logic [ADDR_W:0] c_afull   = c_cnt_w'(AFULL_TH);
   localparam logic [ADDR_W:0] c_aempty  = c_cnt_w'(AEMPTY_TH);

   generate
      if (!fifo_th_ok(AEMPTY_TH, AFULL_TH, c_depth_i)) begin : g_bad_thresholds
         $fatal(1, "sync_fifo_param: require AEMPTY_TH < AFULL_TH <= DEPTH");
      end
   endgenerate

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_accept;
   logic              wr_accept;

   // Flags decode the count register only, so no input reaches them.
   assign full         = (count_q == c_depth);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= c_afull);
   assign almost_empty = (count_q <= c_aempty);
   assign count        = count_q;
   assign rd_valid     = rd_valid_q;

   // A full FIFO still takes a write when a read frees a slot this cycle.
   assign rd_accept = rd_en & ~empty;
   assign wr_accept = wr_en & (~full | rd_accept);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = rd_accept;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   fifo_dp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_accept),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .re    (rd_accept),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

`ifdef SHA3_FIFO_ERRFLAG_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Clear wins over a set arriving in the same cycle.
   always_comb begin
      overflow_d  = overflow_q | (wr_en & ~wr_accept);
      underflow_d = underflow_q | (rd_en & empty);
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench for sync_fifo_param (default
//               parameters; error-flag expectations follow SHA3_FIFO_ERRFLAG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

   localparam int DW    = 16;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

`ifdef SHA3_FIFO_ERRFLAG_EN
   localparam logic c_errflag = 1'b1;
`else
   localparam logic c_errflag = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int n_tests = 0;
   int n_fail  = 0;

   sync_fifo_param dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_count"}, 32'(count), 32'd0);
      check_eq({tag, "_empty"}, 32'(empty), 32'd1);
      check_eq({tag, "_full"}, 32'(full), 32'd0);
      check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check_eq({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      check_eq({tag, "_aempty"}, 32'(almost_empty), 32'd1);
      check_eq({tag, "_afull"}, 32'(almost_full), 32'd0);
      check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
      check_eq({tag, "_unf"}, 32'(underflow), 32'd0);
   endtask

   function automatic logic [DW-1:0] fill_word(input int i);
      return DW'(i) ^ 16'hA500;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] q[$];
      logic [DW-1:0] exp_word;
      logic          exp_valid;

      // ---- 1: reset and a short in-order transfer ----
      #12;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();
      for (int i = 1; i <= 5; i++) begin
         wr_en   = 1'b1;
         wr_data = DW'(i);
         tick();
      end
      wr_en = 1'b0;
      check_eq("t1_count5", 32'(count), 32'd5);
      for (int i = 1; i <= 5; i++) begin
         rd_en = 1'b1;
         tick();
         check_eq("t1_rd_valid", 32'(rd_valid), 32'd1);
         check_eq("t1_rd_data", 32'(rd_data), 32'(i));
      end
      rd_en = 1'b0;
      tick();
      check_eq("t1_valid_drop", 32'(rd_valid), 32'd0);
      check_eq("t1_hold_data", 32'(rd_data), 32'd5);
      check_eq("t1_empty", 32'(empty), 32'd1);
      check_eq("t1_count0", 32'(count), 32'd0);

      // ---- 2 + 5: fill to full, threshold edges, rejected write ----
      for (int k = 1; k <= DEPTH; k++) begin
         wr_en   = 1'b1;
         wr_data = fill_word(k - 1);
         tick();
         if (k == 4) check_eq("t5_aempty_at4", 32'(almost_empty), 32'd1);
         if (k == 5) check_eq("t5_aempty_at5", 32'(almost_empty), 32'd0);
         if (k == 507) check_eq("t5_afull_at507", 32'(almost_full), 32'd0);
         if (k == 508) check_eq("t5_afull_at508", 32'(almost_full), 32'd1);
         if (k == 511) check_eq("t2_notfull_511", 32'(full), 32'd0);
      end
      check_eq("t2_full", 32'(full), 32'd1);
      check_eq("t2_count512", 32'(count), 32'd512);
      check_eq("t2_ovf_before", 32'(overflow), 32'd0);
      wr_data = 16'hDEAD;
      tick();
      wr_en = 1'b0;
      check_eq("t2_count_after_reject", 32'(count), 32'd512);
      check_eq("t2_ovf", 32'(overflow), 32'(c_errflag));

      // ---- 3: write-through while full ----
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      check_eq("t3_count", 32'(count), 32'd512);
      check_eq("t3_rd_valid", 32'(rd_valid), 32'd1);
      check_eq("t3_oldest", 32'(rd_data), 32'(fill_word(0)));
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         exp_word = (k == DEPTH) ? 16'hBEEF : fill_word(k);
         check_eq("t3_drain", 32'(rd_data), 32'(exp_word));
      end
      rd_en = 1'b0;
      tick();
      check_eq("t3_empty", 32'(empty), 32'd1);
      check_eq("t3_unf_clean", 32'(underflow), 32'd0);

      // ---- 4: simultaneous read/write on empty, then err_clr ----
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 16'h1234;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_eq("t4_no_bypass", 32'(rd_valid), 32'd0);
      check_eq("t4_count1", 32'(count), 32'd1);
      check_eq("t4_unf", 32'(underflow), 32'(c_errflag));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_eq("t4_rd_valid", 32'(rd_valid), 32'd1);
      check_eq("t4_rd_data", 32'(rd_data), 32'h1234);
      // Clear coincides with a fresh underflow attempt; clear must win.
      err_clr = 1'b1;
      rd_en   = 1'b1;
      tick();
      err_clr = 1'b0;
      rd_en   = 1'b0;
      check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
      check_eq("t4_unf_clr", 32'(underflow), 32'd0);
      check_eq("t4_hold_data", 32'(rd_data), 32'h1234);

      // ---- 6: 600 writes with interleaved reads, then async reset ----
      for (int i = 0; i < 600; i++) begin
         wr_en     = 1'b1;
         wr_data   = 16'h6000 + DW'(i);
         rd_en     = (i % 3 == 0);
         exp_valid = rd_en && (q.size() > 0);
         if (exp_valid) exp_word = q.pop_front();
         q.push_back(wr_data);
         tick();
         check_eq("t6_rd_valid", 32'(rd_valid), 32'(exp_valid));
         if (exp_valid) check_eq("t6_rd_data", 32'(rd_data), 32'(exp_word));
         check_eq("t6_count", 32'(count), 32'(q.size()));
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      check_eq("t6_empty_after", 32'(empty), 32'd1);
      wr_en   = 1'b1;
      wr_data = 16'h5A5A;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_eq("t6_new_valid", 32'(rd_valid), 32'd1);
      check_eq("t6_new_data", 32'(rd_data), 32'h5A5A);
      check_eq("t6_new_empty", 32'(empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
